// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter: state encoding,
// requester count, default hold limit and the round-robin search helper.
package mux4_rr_arbiter_pkg;

  localparam int N_REQ            = 4;
  localparam int DEFAULT_MAX_HOLD = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // First set request bit found when searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4_mux2.sv
// Existing 4:1 mux built from two levels of 2:1 muxes; s1 picks within a
// pair, s0 picks between the pairs {i0,i1} and {i2,i3}.
module mux4_mux2 (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s1,
  input  logic s0,
  output logic y
);

  logic lo_pair;
  logic hi_pair;

  assign lo_pair = s1 ? i1 : i0;
  assign hi_pair = s1 ? i3 : i2;
  assign y       = s0 ? hi_pair : lo_pair;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns a shared 4:1 mux; the owner keeps the mux
// for up to MAX_HOLD cycles, then ownership rotates without an idle bubble.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       dout,
  output logic       valid
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  arb_state_t state, state_nxt;
  logic [1:0] sel, sel_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic [3:0] gnt_nxt;
  logic       release_now;
  logic       mux_out;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sel      <= 2'd0;
      ptr      <= 2'd0;
      hold_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next-state: sel is left untouched on return to IDLE so s1/s0 hold.
  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    release_now = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          state_nxt = ST_GRANT;
          sel_nxt   = rr_pick(req, ptr);
          hold_nxt  = 4'd0;
        end
      end
      ST_GRANT: begin
        release_now = !req[sel] || (hold_cnt == HOLD_LAST);
        if (!release_now) begin
          hold_nxt = hold_cnt + 4'd1;
        end else begin
          ptr_nxt  = sel + 2'd1;
          hold_nxt = 4'd0;
          if (|req) begin
            sel_nxt = rr_pick(req, sel + 2'd1);
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered below
  always_comb begin
    gnt_nxt = 4'b0000;
    if (state_nxt == ST_GRANT) begin
      gnt_nxt = 4'b0001 << sel_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt <= 4'b0000;
    end else begin
      gnt <= gnt_nxt;
    end
  end

  assign valid = (state == ST_GRANT);
  assign s1    = sel[0];
  assign s0    = sel[1];

  mux4_mux2 u_mux (
    .i0 (din[0]),
    .i1 (din[1]),
    .i2 (din[2]),
    .i3 (din[3]),
    .s1 (s1),
    .s0 (s0),
    .y  (mux_out)
  );

  assign dout = valid & mux_out;

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 4, maximum consecutive grant cycles per owner (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req  input  4  request per requester; bit k = requester k.
REQ-005 din  input  4  data per requester; bit k routes to mux input ik.
REQ-006 gnt  output  4  one-hot grant, registered; all-zero when no owner.
REQ-007 s1  output  1  mux select, registered.
REQ-008 s0  output  1  mux select, registered.
REQ-009 dout  output  1  shared mux output, gated to 0 when valid=0.
REQ-010 valid  output  1  high while an owner holds the mux (state GRANT).

Function
REQ-011 The FSM SHALL have two states: IDLE (no owner) and GRANT (one owner, index sel[1:0]).
REQ-012 IDLE: when req!=0 at a rising edge, the FSM SHALL enter GRANT with the owner chosen by round-robin from pointer ptr; one-cycle grant latency.
REQ-013 Round-robin: the search order SHALL be ptr, ptr+1, ptr+2, ptr+3 (mod 4), and the first set req bit wins.
REQ-014 GRANT: the owner SHALL keep the grant while req[sel]=1 and hold_cnt < MAX_HOLD-1; hold_cnt SHALL increment each held cycle.
REQ-015 Release: release SHALL occur at the edge where req[sel]=0 or hold_cnt = MAX_HOLD-1.
REQ-016 At release, ptr SHALL become sel+1 mod 4.
REQ-017 At release, if any req bit is set, re-arbitration SHALL use the new ptr and grant the winner on the same edge, with no idle bubble.
REQ-018 At release, if no req bit is set, the FSM SHALL return to IDLE.
REQ-019 A sole requester SHALL be re-granted after a MAX_HOLD expiry (search wraps to it last), and hold_cnt SHALL restart at 0.
REQ-020 Select mapping: owner 0 -> s1=0,s0=0; owner 1 -> s1=1,s0=0; owner 2 -> s1=0,s0=1; owner 3 -> s1=1,s0=1 (s1=sel[0], s0=sel[1]).
REQ-021 s1/s0 SHALL hold their last value in IDLE.
REQ-022 dout SHALL equal din[sel] combinationally when valid=1, else 0.
REQ-023 gnt SHALL be exactly one-hot in GRANT and zero in IDLE; gnt, valid, s1, s0 SHALL change only on clock edges.
REQ-024 A requester that drops req without holding the grant SHALL have no effect.
REQ-025 A req pulse shorter than one cycle that is not sampled at an edge SHALL be ignored.

Reset
REQ-026 rst_n=0 SHALL immediately force: state=IDLE, gnt=0, valid=0, dout=0, s1=0, s0=0, ptr=0, hold_cnt=0, independent of clk.
REQ-027 Reset asserted mid-grant SHALL abort the grant with no completion cycle.
REQ-028 After rst_n rises, the first arbitration SHALL start from ptr=0.

Structure
REQ-029 A shared include file mux_arb_defs.vh SHALL define the state encodings (IDLE=0, GRANT=1), the requester count (4) and the default MAX_HOLD.
REQ-030 The datapath SHALL be one instance of the team's existing 4:1 mux module mux4_mux2, driven by din[3:0] and the registered s1/s0.
REQ-031 The arbiter SHALL add only the AND-gate on dout and no second mux.

Verification
REQ-032 Reset: rst_n=0 mid-GRANT (owner 2) -> same instant gnt=0000, valid=0, s1=s0=0; after release, req=0001 -> gnt=0001 one edge later.
REQ-033 Single requester: req=0100, din=0100 -> next edge gnt=0100, s1=0, s0=1, dout=1; held 4 cycles; re-granted with no gap, hold_cnt restarted.
REQ-034 Round-robin fairness: req=1111 held for 16 cycles with MAX_HOLD=4 -> grant order 0,1,2,3, each exactly 4 cycles, valid never low.
REQ-035 Early release: owner 1 drops req after 2 cycles while req[3]=1 -> gnt moves 0010 -> 1000 on that edge, s1=1, s0=1.
REQ-036 Simultaneous events: owner 3 at hold expiry with req=1001 -> next owner 0 (wrap); ptr=0.
REQ-037 Mapping sweep: for each owner k, toggle din[k] only -> dout follows din[k]; toggling other din bits -> dout unchanged.
